// File: rtl/interp_div_seq.sv
// Pilot-pair time interpolator: est3 + d/3 and est3 + 2d/3 via a sequential restoring divide-by-3,
// then sequences sel est3 -> div_res_1 -> div_res_2 -> est4. Optional macro: ROUND_NEAREST_EN.
module interp_div_seq #(
  parameter int WIDTH = 17
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [WIDTH-1:0] est3,
  input  logic signed [WIDTH-1:0] est4,
  input  logic                    est_valid,
  output logic                    est_ready,
  output logic signed [WIDTH-1:0] div_res_1,
  output logic signed [WIDTH-1:0] div_res_2,
  output logic [1:0]              sel,
  output logic                    h_valid,
  input  logic                    h_ready,
  output logic                    busy
);

  // state | meaning
  // IDLE  | waiting for an estimate pair
  // LOAD  | form |est4 - est3| and its sign
  // DIV   | one restoring quotient bit per cycle, MSB first
  // ADD   | apply signed quotient to est3
  // OUT   | present four ordered samples to the mux
  localparam int DW = WIDTH + 1;
  localparam int CW = $clog2(DW);

  typedef enum logic [2:0] {IDLE, LOAD, DIV, ADD, OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [WIDTH-1:0]   est3_q, est3_d, est4_q, est4_d;
  logic signed [WIDTH-1:0]   res1_q, res1_d, res2_q, res2_d;
  logic                      neg_q, neg_d;
  logic [DW-1:0]             quo_q, quo_d;
  logic [1:0]                rem_q, rem_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [1:0]                sel_q, sel_d;

  logic signed [DW-1:0]      diff;
  logic [DW-1:0]             mag;
  logic [DW-1:0]             mag_src;
  logic [2:0]                trial;
  logic [2:0]                trial_sub;
  logic                      trial_ge;
  logic signed [DW:0]        q_s;
  logic signed [DW:0]        q2_s;
  logic signed [DW:0]        e3_x;
  logic signed [DW:0]        sum1;
  logic signed [DW:0]        sum2;

  always_comb begin
    diff = {est4_q[WIDTH-1], est4_q} - {est3_q[WIDTH-1], est3_q};
    mag  = diff[DW-1] ? DW'(-diff) : DW'(diff);
`ifdef ROUND_NEAREST_EN
    // |d| <= 2^WIDTH-1, so the +1 still fits the DW-bit magnitude.
    mag_src = mag + DW'(1);
`else
    mag_src = mag;
`endif
    trial     = {rem_q, quo_q[DW-1]};
    trial_ge  = (trial >= 3'd3);
    trial_sub = trial - 3'd3;
    q_s  = neg_q ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});
    q2_s = {q_s[DW-1:0], 1'b0};
    e3_x = {{2{est3_q[WIDTH-1]}}, est3_q};
    sum1 = e3_x + q_s;
    sum2 = e3_x + q2_s;
  end

  always_comb begin
    state_d = state_q;
    est3_d  = est3_q;
    est4_d  = est4_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    neg_d   = neg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (est_valid) begin
          est3_d  = est3;
          est4_d  = est4;
          state_d = LOAD;
        end
      end
      LOAD: begin
        neg_d   = diff[DW-1];
        quo_d   = mag_src;
        rem_d   = 2'd0;
        cnt_d   = CW'(DW - 1);
        state_d = DIV;
      end
      DIV: begin
        // Dividend bits shift out the top while quotient bits shift in at the bottom.
        rem_d = trial_ge ? trial_sub[1:0] : trial[1:0];
        quo_d = {quo_q[DW-2:0], trial_ge};
        if (cnt_q == '0) state_d = ADD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ADD: begin
        // Results lie between est3 and est4, so truncation to WIDTH is lossless.
        res1_d  = sum1[WIDTH-1:0];
        res2_d  = sum2[WIDTH-1:0];
        sel_d   = 2'b01;
        state_d = OUT;
      end
      OUT: begin
        if (h_ready) begin
          unique case (sel_q)
            2'b01: sel_d = 2'b10;
            2'b10: sel_d = 2'b00;
            2'b00: sel_d = 2'b11;
            default: begin
              sel_d   = 2'b01;
              state_d = IDLE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      est3_q  <= '0;
      est4_q  <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      neg_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 2'b01;
    end else begin
      state_q <= state_d;
      est3_q  <= est3_d;
      est4_q  <= est4_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      neg_q   <= neg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign est_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign h_valid   = (state_q == OUT);
  assign sel       = sel_q;
  assign div_res_1 = res1_q;
  assign div_res_2 = res2_q;

endmodule

// File: tb/tb_interp_div_seq.sv
// Directed self-checking bench for interp_div_seq; expectations follow ROUND_NEAREST_EN when defined.
module tb_interp_div_seq;
  localparam int W = 17;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic signed [W-1:0] est3 = '0;
  logic signed [W-1:0] est4 = '0;
  logic                est_valid = 1'b0;
  logic                est_ready;
  logic signed [W-1:0] div_res_1;
  logic signed [W-1:0] div_res_2;
  logic [1:0]          sel;
  logic                h_valid;
  logic                h_ready = 1'b1;
  logic                busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_sel [4] = '{2'b01, 2'b10, 2'b00, 2'b11};

  interp_div_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .est3(est3), .est4(est4), .est_valid(est_valid),
    .est_ready(est_ready), .div_res_1(div_res_1), .div_res_2(div_res_2),
    .sel(sel), .h_valid(h_valid), .h_ready(h_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one pair for a single accept edge; returns edges from accept to first h_valid.
  task automatic start_pair(input int a, input int b, output int lat);
    est3 = W'(a);
    est4 = W'(b);
    est_valid = 1'b1;
    tick();
    est_valid = 1'b0;
    lat = 0;
    while (!h_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    h_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    n_cmp++; if (est_ready !== 1'b1) begin n_err++; $display("FAIL rst_est_ready got %b exp 1", est_ready); end
    n_cmp++; if (div_res_1 !== 0) begin n_err++; $display("FAIL rst_res1 got %0d exp 0", div_res_1); end
    n_cmp++; if (div_res_2 !== 0) begin n_err++; $display("FAIL rst_res2 got %0d exp 0", div_res_2); end
    n_cmp++; if (sel !== 2'b01) begin n_err++; $display("FAIL rst_sel got %b exp 01", sel); end
    n_cmp++; if (h_valid !== 1'b0) begin n_err++; $display("FAIL rst_h_valid got %b exp 0", h_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    @(negedge CLK);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    h_ready = 1'b1;
    start_pair(300, 900, lat);
    // first h_valid is observed right after edge E0+W+3
    n_cmp++; if (lat !== W + 3) begin n_err++; $display("FAIL basic_latency got %0d exp %0d", lat, W + 3); end
    n_cmp++; if (div_res_1 !== 500) begin n_err++; $display("FAIL basic_res1 got %0d exp 500", div_res_1); end
    n_cmp++; if (div_res_2 !== 700) begin n_err++; $display("FAIL basic_res2 got %0d exp 700", div_res_2); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (h_valid !== 1'b1) begin n_err++; $display("FAIL basic_hv%0d got %b exp 1", i, h_valid); end
      n_cmp++; if (sel !== exp_sel[i]) begin n_err++; $display("FAIL basic_sel%0d got %b exp %b", i, sel, exp_sel[i]); end
      tick();
    end
    n_cmp++; if (h_valid !== 1'b0) begin n_err++; $display("FAIL basic_end_hv got %b exp 0", h_valid); end
    n_cmp++; if (est_ready !== 1'b1) begin n_err++; $display("FAIL basic_end_ready got %b exp 1", est_ready); end
    n_cmp++; if (sel !== 2'b01) begin n_err++; $display("FAIL basic_end_sel got %b exp 01", sel); end
  endtask

  task automatic test_negative();
    int lat;
    int e1, e2;
`ifdef ROUND_NEAREST_EN
    e1 = 33;  e2 = -34;
`else
    e1 = 34;  e2 = -32;
`endif
    start_pair(100, -100, lat);
    n_cmp++; if (h_valid !== 1'b1) begin n_err++; $display("FAIL neg_timeout got %b exp 1", h_valid); end
    n_cmp++; if (div_res_1 !== e1) begin n_err++; $display("FAIL neg_res1 got %0d exp %0d", div_res_1, e1); end
    n_cmp++; if (div_res_2 !== e2) begin n_err++; $display("FAIL neg_res2 got %0d exp %0d", div_res_2, e2); end
    drain();
  endtask

  task automatic test_extreme();
    int lat;
    start_pair(-65536, 65535, lat);
    n_cmp++; if (h_valid !== 1'b1) begin n_err++; $display("FAIL ext_timeout got %b exp 1", h_valid); end
    n_cmp++; if (div_res_1 !== -21846) begin n_err++; $display("FAIL ext_res1 got %0d exp -21846", div_res_1); end
    n_cmp++; if (div_res_2 !== 21844) begin n_err++; $display("FAIL ext_res2 got %0d exp 21844", div_res_2); end
    drain();
    start_pair(65535, -65536, lat);
    n_cmp++; if (div_res_1 !== 21845) begin n_err++; $display("FAIL ext_rev_res1 got %0d exp 21845", div_res_1); end
    n_cmp++; if (div_res_2 !== -21845) begin n_err++; $display("FAIL ext_rev_res2 got %0d exp -21845", div_res_2); end
    drain();
  endtask

  task automatic test_stall();
    int lat;
    int idx;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    start_pair(-5, -5, lat);
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      h_ready = pat[i];
      n_cmp++; if (h_valid !== 1'b1) begin n_err++; $display("FAIL stall_hv%0d got %b exp 1", i, h_valid); end
      n_cmp++; if (sel !== exp_sel[idx]) begin n_err++; $display("FAIL stall_sel%0d got %b exp %b", i, sel, exp_sel[idx]); end
      n_cmp++; if (div_res_1 !== -5 || div_res_2 !== -5) begin
        n_err++; $display("FAIL stall_val%0d got %0d/%0d exp -5/-5", i, div_res_1, div_res_2);
      end
      tick();
      if (pat[i]) idx++;
    end
    h_ready = 1'b1;
    n_cmp++; if (h_valid !== 1'b0) begin n_err++; $display("FAIL stall_end_hv got %b exp 0", h_valid); end
  endtask

  task automatic test_back_to_back();
    int viol;
    int cyc;
    int extra;
    viol = 0;
    h_ready = 1'b1;
    est3 = 17'sd10;
    est4 = 17'sd40;
    est_valid = 1'b1;
    tick();
    est3 = 17'sd0;
    est4 = 17'sd9;
    cyc = 0;
    while (!h_valid && cyc < 60) begin
      if (est_ready) viol++;
      tick();
      cyc++;
    end
    n_cmp++; if (div_res_1 !== 20 || div_res_2 !== 30) begin
      n_err++; $display("FAIL b2b_a got %0d/%0d exp 20/30", div_res_1, div_res_2);
    end
    for (int i = 0; i < 4; i++) begin
      if (est_ready) viol++;
      tick();
    end
    n_cmp++; if (est_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle got ready=%b busy=%b exp 1/0", est_ready, busy);
    end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_b got %b exp 1", busy); end
    cyc = 0;
    while (!h_valid && cyc < 60) begin
      if (est_ready) viol++;
      tick();
      cyc++;
    end
    n_cmp++; if (div_res_1 !== 3 || div_res_2 !== 6) begin
      n_err++; $display("FAIL b2b_b got %0d/%0d exp 3/6", div_res_1, div_res_2);
    end
    for (int i = 0; i < 4; i++) begin
      if (est_ready) viol++;
      if (i == 3) est_valid = 1'b0;
      tick();
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) extra++;
      tick();
    end
    n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL b2b_ready_low got %0d exp 0", viol); end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL b2b_no_dup got %0d exp 0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat;
    est3 = 17'sd1000;
    est4 = 17'sd1600;
    est_valid = 1'b1;
    tick();
    est_valid = 1'b0;
    repeat (6) tick();
    #2 RST = 1'b1;
    #1;
    n_cmp++; if (est_ready !== 1'b1 || busy !== 1'b0 || h_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_ctrl got ready=%b busy=%b hv=%b exp 1/0/0", est_ready, busy, h_valid);
    end
    n_cmp++; if (div_res_1 !== 0 || div_res_2 !== 0 || sel !== 2'b01) begin
      n_err++; $display("FAIL mid_rst_data got %0d/%0d sel=%b exp 0/0 sel=01", div_res_1, div_res_2, sel);
    end
    @(negedge CLK);
    RST = 1'b0;
    tick();
    start_pair(300, 900, lat);
    n_cmp++; if (lat !== W + 3) begin n_err++; $display("FAIL mid_latency got %0d exp %0d", lat, W + 3); end
    n_cmp++; if (div_res_1 !== 500 || div_res_2 !== 700) begin
      n_err++; $display("FAIL mid_after got %0d/%0d exp 500/700", div_res_1, div_res_2);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_extreme();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
